// File: rtl/amber48_encoder.sv
// amber48 instruction encoder: packs field-level commands into 48-bit words and
// expands the LI pseudo-op into UPPER_IMM / ADD_IMM pairs behind a registered output.
module amber48_encoder #(
  parameter int          XLEN      = 48,
  parameter logic [7:0]  OPCODE_LI = 8'hFF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [7:0]      cmd_op_i,
  input  logic [3:0]      cmd_rd_i,
  input  logic [3:0]      cmd_rs1_i,
  input  logic [3:0]      cmd_rs2_i,
  input  logic [XLEN-1:0] cmd_imm_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_last_o,
  output logic            cmd_err_o
);

  localparam logic [7:0] OP_UPPER_IMM = 8'h00;
  localparam logic [7:0] OP_ADD_IMM   = 8'h11;

  typedef enum logic {IDLE, EMIT_LO} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_valid, r_last, r_err;
  logic [XLEN-1:0] r_instr, r_pend;

  logic            w_free, w_accept, w_is_li;
  logic            w_legal, w_li_ok, w_li_two;
  logic [XLEN-1:0] w_word, w_li_first, w_li_second;
  logic [23:0]     w_h, w_l, w_hi;
  logic [15:0]     w_lo;

  function automatic logic [XLEN-1:0] f_pack(input logic [7:0] op, input logic [3:0] rd,
                                             input logic [3:0] rs1, input logic [3:0] rs2,
                                             input logic [15:0] imm16);
    return {op, imm16, rs1, rs2, rd, 12'h000};
  endfunction

  assign w_free      = !r_valid || instr_ready_i;
  assign cmd_ready_o = (r_state == IDLE) && w_free;
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_is_li     = (cmd_op_i == OPCODE_LI);

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (cmd_op_i)
      8'h00: w_word = {OP_UPPER_IMM, cmd_imm_i[23:0], cmd_rd_i, 12'h000};
      8'h10, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31:
        w_word = f_pack(cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, 16'h0000);
      8'h11, 8'h13, 8'h23:
        w_word = f_pack(cmd_op_i, cmd_rd_i, cmd_rs1_i, 4'h0, cmd_imm_i[15:0]);
      8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h61:
        w_word = f_pack(cmd_op_i, 4'h0, cmd_rs1_i, cmd_rs2_i, cmd_imm_i[15:0]);
      8'h46, 8'h47, 8'h48:
        w_word = f_pack(cmd_op_i, 4'h0, cmd_rs1_i, 4'h0, cmd_imm_i[15:0]);
      8'h60:
        w_word = f_pack(cmd_op_i, cmd_rd_i, cmd_rs1_i, 4'h0, cmd_imm_i[15:0]);
      8'h70, 8'h71:
        w_word = f_pack(cmd_op_i, 4'h0, 4'h0, 4'h0, cmd_imm_i[15:0]);
      8'h72:
        w_word = f_pack(cmd_op_i, 4'h0, cmd_rs1_i, 4'h0, 16'h0000);
      default: w_legal = 1'b0;
    endcase
  end

  // LO is sign-extended by ADD_IMM, so a negative LO borrows one from HI.
  always_comb begin
    w_h         = cmd_imm_i[47:24];
    w_l         = cmd_imm_i[23:0];
    w_lo        = w_l[15:0];
    w_li_ok     = 1'b1;
    w_hi        = w_h;
    if (w_l >= 24'hFF8000)     w_hi = w_h + 24'd1;
    else if (w_l >= 24'h008000) w_li_ok = 1'b0;
    w_li_two    = (w_hi != 24'd0) && (w_lo != 16'd0);
    w_li_second = f_pack(OP_ADD_IMM, cmd_rd_i, cmd_rd_i, 4'h0, w_lo);
    w_li_first  = (w_hi != 24'd0) ? {OP_UPPER_IMM, w_hi, cmd_rd_i, 12'h000}
                                  : f_pack(OP_ADD_IMM, cmd_rd_i, 4'h0, 4'h0, w_lo);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_li && w_li_ok && w_li_two) w_state_nxt = EMIT_LO;
      EMIT_LO: if (w_free) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_valid && instr_ready_i) r_valid <= 1'b0;
      if (r_state == EMIT_LO) begin
        if (w_free) begin
          r_valid <= 1'b1;
          r_instr <= r_pend;
          r_last  <= 1'b1;
        end
      end else if (w_accept) begin
        if (w_is_li) begin
          if (w_li_ok) begin
            r_valid <= 1'b1;
            r_instr <= w_li_first;
            r_last  <= !w_li_two;
            r_pend  <= w_li_second;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_legal) begin
          r_valid <= 1'b1;
          r_instr <= w_word;
          r_last  <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_last_o  = r_last;
  assign cmd_err_o     = r_err;

endmodule

// File: tb/tb_amber48_encoder.sv
// Directed bench for amber48_encoder: hand-computed words, LI expansion, stalls, errors, reset.
module tb_amber48_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_op_i;
  logic [3:0]  cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
  logic [47:0] cmd_imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [47:0] instr_o;
  logic        instr_last_o;
  logic        cmd_err_o;

  int nvec  = 0;
  int nfail = 0;

  amber48_encoder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_rd_i     (cmd_rd_i),
    .cmd_rs1_i    (cmd_rs1_i),
    .cmd_rs2_i    (cmd_rs2_i),
    .cmd_imm_i    (cmd_imm_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_last_o (instr_last_o),
    .cmd_err_o    (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expects the output port as a whole: valid, word, last, err.
  task automatic chk_out(input string tag, input logic v, input logic [47:0] w,
                         input logic l, input logic e);
    chk({tag, ".valid"}, {47'd0, instr_valid_o}, {47'd0, v});
    if (v) begin
      chk({tag, ".instr"}, instr_o, w);
      chk({tag, ".last"}, {47'd0, instr_last_o}, {47'd0, l});
    end
    chk({tag, ".err"}, {47'd0, cmd_err_o}, {47'd0, e});
  endtask

  task automatic send(input string tag, input logic [7:0] op, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [47:0] imm);
    cmd_op_i    = op;
    cmd_rd_i    = rd;
    cmd_rs1_i   = rs1;
    cmd_rs2_i   = rs2;
    cmd_imm_i   = imm;
    cmd_valid_i = 1'b1;
    #0;
    chk({tag, ".cmd_ready"}, {47'd0, cmd_ready_o}, 48'd1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; instr_ready_i = 1'b1;
    cmd_op_i = '0; cmd_rd_i = '0; cmd_rs1_i = '0; cmd_rs2_i = '0; cmd_imm_i = '0;
    #2;
    chk("rst.valid", {47'd0, instr_valid_o}, 48'd0);
    chk("rst.instr", instr_o, 48'd0);
    chk("rst.last",  {47'd0, instr_last_o}, 48'd0);
    chk("rst.err",   {47'd0, cmd_err_o}, 48'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Back-to-back single-word ops at full throughput
    send("add_reg", 8'h10, 4'd3, 4'd1, 4'd2, 48'h0);
    chk_out("add_reg", 1'b1, 48'h1000_0012_3000, 1'b1, 1'b0);
    send("bz", 8'h46, 4'd7, 4'd2, 4'd9, 48'h0004);
    chk_out("bz", 1'b1, 48'h4600_0420_0000, 1'b1, 1'b0);
    send("store", 8'h61, 4'd3, 4'd1, 4'd2, 48'hFFFF_FFFF_0008);
    chk_out("store", 1'b1, 48'h6100_0812_0000, 1'b1, 1'b0);
    send("jump", 8'h70, 4'd5, 4'd6, 4'd7, 48'h1234);
    chk_out("jump", 1'b1, 48'h7012_3400_0000, 1'b1, 1'b0);
    send("ret", 8'h72, 4'd1, 4'd5, 4'd3, 48'hFFFF);
    chk_out("ret", 1'b1, 48'h7200_0050_0000, 1'b1, 1'b0);

    // LI, small positive low half
    send("li1", 8'hFF, 4'd4, 4'd0, 4'd0, 48'h0000_1200_0010);
    chk_out("li1.w0", 1'b1, 48'h0000_0012_4000, 1'b0, 1'b0);
    chk("li1.busy", {47'd0, cmd_ready_o}, 48'd0);
    tick();
    chk_out("li1.w1", 1'b1, 48'h1100_1040_4000, 1'b1, 1'b0);
    chk("li1.free", {47'd0, cmd_ready_o}, 48'd1);
    tick();
    chk_out("li1.drain", 1'b0, 48'h0, 1'b0, 1'b0);

    // LI, negative low half borrows into HI
    send("li2", 8'hFF, 4'd4, 4'd0, 4'd0, 48'h0000_12FF_FFF0);
    chk_out("li2.w0", 1'b1, 48'h0000_0013_4000, 1'b0, 1'b0);
    tick();
    chk_out("li2.w1", 1'b1, 48'h11FF_F040_4000, 1'b1, 1'b0);

    send("li3", 8'hFF, 4'd4, 4'd0, 4'd0, 48'h7);
    chk_out("li3", 1'b1, 48'h1100_0700_4000, 1'b1, 1'b0);
    send("li_bad", 8'hFF, 4'd4, 4'd0, 4'd0, 48'h0000_1234_0010);
    chk_out("li_bad", 1'b0, 48'h0, 1'b0, 1'b1);
    tick();
    chk_out("li_bad.end", 1'b0, 48'h0, 1'b0, 1'b0);

    send("illegal", 8'h50, 4'd1, 4'd2, 4'd3, 48'h0);
    chk_out("illegal", 1'b0, 48'h0, 1'b0, 1'b1);
    tick();
    chk_out("illegal.end", 1'b0, 48'h0, 1'b0, 1'b0);

    // Backpressure: word must hold while consumer stalls
    instr_ready_i = 1'b0;
    send("stall", 8'h13, 4'd5, 4'd6, 4'd15, 48'hABCD);
    chk_out("stall", 1'b1, 48'h13AB_CD60_5000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall.hold", 1'b1, 48'h13AB_CD60_5000, 1'b1, 1'b0);
      chk("stall.cmd_ready", {47'd0, cmd_ready_o}, 48'd0);
    end
    instr_ready_i = 1'b1;
    #1;
    chk("stall.release", {47'd0, cmd_ready_o}, 48'd1);
    tick();
    chk_out("stall.drain", 1'b0, 48'h0, 1'b0, 1'b0);

    // Reset during EMIT_LO drops the pending word
    send("li_rst", 8'hFF, 4'd4, 4'd0, 4'd0, 48'h0000_1200_0010);
    chk_out("li_rst.w0", 1'b1, 48'h0000_0012_4000, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("li_rst.async_valid", {47'd0, instr_valid_o}, 48'd0);
    chk("li_rst.async_instr", instr_o, 48'd0);
    #1 rst_i = 1'b0;
    tick();
    chk_out("li_rst.after", 1'b0, 48'h0, 1'b0, 1'b0);
    chk("li_rst.idle", {47'd0, cmd_ready_o}, 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/amber48_encoder.md
Name:
amber48_encoder

Overview:
- Instruction encoder: inverse of the amber48 decode stage.
- Accepts field-level encode commands (ISA opcode, rd, rs1, rs2, imm) on a valid/ready interface and emits packed 48-bit amber48 instruction words on a registered valid/ready output.
- Also expands the LI pseudo-op into one or two real instructions, so the 48-bit constant is reconstructed exactly by the decode/execute path.
- Used by the debug/boot instruction injector and by self-checking testbenches.

Parameters:
- XLEN, 48, instruction and data width (from amber48_pkg; fixed at 48).
- OPCODE_LI, 8'hFF, pseudo-opcode that selects the load-immediate macro.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- cmd_valid_i  input  1  encode command valid
- cmd_ready_o  output  1  encoder can accept a command this cycle
- cmd_op_i  input  8  ISA opcode, or OPCODE_LI
- cmd_rd_i  input  4  destination register field
- cmd_rs1_i  input  4  source 1 register field
- cmd_rs2_i  input  4  source 2 register field
- cmd_imm_i  input  48  immediate: 16 LSBs for normal ops, 24 LSBs for UPPER_IMM, full 48-bit value for LI
- instr_valid_o  output  1  instr_o holds a valid instruction word
- instr_ready_i  input  1  consumer accepts instr_o
- instr_o  output  48  packed instruction word
- instr_last_o  output  1  final word of the current command
- cmd_err_o  output  1  one-cycle pulse: command rejected

Behaviour:
- One clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: instr_valid_o=0, instr_o=0, instr_last_o=0, cmd_err_o=0, FSM=IDLE.
- Word layout:
  - [47:40] opcode; [39:24] imm16; [23:20] rs1; [19:16] rs2; [15:12] rd; [11:0]=0.
  - UPPER_IMM (8'h00) places cmd_imm_i[23:0] in [39:16].
- Field rules by opcode group. Fields not listed are taken from the command. All unused fields are forced to 0.
  - ALU register ops 10/12/20/21/22/30/31: rd, rs1, rs2; imm16=0.
  - ALU immediate ops 11/13/23: rd, rs1, imm16; rs2=0.
  - Branches 40–45: rs1, rs2, imm16; rd=0.
  - Branches 46/47/48: rs1, imm16; rd=0, rs2=0.
  - LOAD 60: rd, rs1, imm16.
  - STORE 61: rs1, rs2, imm16; rd=0.
  - JUMP 70 / JUMP_SUB 71: imm16 only; rd, rs1, rs2 = 0.
  - RETURN 72: rs1 only; imm16=0.
- Handshakes:
  - Output slot is free when instr_valid_o=0 or instr_ready_i=1.
  - cmd_ready_o = (FSM==IDLE) && output slot free.
  - Command is accepted on cmd_valid_i && cmd_ready_o.
  - Output word is consumed on instr_valid_o && instr_ready_i.
  - instr_o and instr_last_o hold stable while instr_valid_o=1 && instr_ready_i=0.
- Latency: a single-word command appears on instr_o the cycle after acceptance, with instr_last_o=1. Full throughput: one word per cycle.
- Illegal opcode (not listed above and not OPCODE_LI):
  - Command is accepted and cmd_err_o pulses the next cycle.
  - No word is emitted; a word already in the output register is preserved.
- LI macro, target value V:
  - Split V: H=V[47:24], L=V[23:0].
  - If L<16'h8000: HI=H, LO=L[15:0].
  - Else if L>=24'hFF8000: HI=(H+1) mod 2^24, LO=L[15:0].
  - Otherwise: error pulse, no words emitted.
  - HI!=0: emit UPPER_IMM(rd, HI). Then, if LO!=0, emit ADD_IMM(rd, rs1=rd, LO).
  - HI==0: emit a single ADD_IMM(rd, rs1=0, LO), including the case LO==0.
  - instr_last_o=1 only on the final word of the expansion.
- FSM: IDLE -> EMIT_LO when LI produces two words. EMIT_LO holds the second word pending and loads it when the output slot is free, then returns to IDLE. cmd_ready_o=0 in EMIT_LO.
- Reset asserted mid-expansion drops the pending word and clears instr_valid_o immediately.

Test Plan:
- ADD_REG rd=3 rs1=1 rs2=2, ready held 1 -> next cycle instr_o=48'h1000_0012_3000, last=1.
- BRANCH_ZERO rd=7 rs1=2 rs2=9 imm=16'h0004 -> instr_o=48'h4600_0420_0000 (rd and rs2 zeroed).
- LI rd=4 V=48'h0000_1200_0010 -> two words:
  - 48'h0000_0012_4000 with last=0;
  - 48'h1100_1040_4000 with last=1.
  - cmd_ready_o=0 between the two words.
- LI rd=4 V=48'h0000_12FF_FFF0 -> 48'h0000_0013_4000, then 48'h11FF_F040_4000.
- LI rd=4 V=48'h7 -> single word 48'h1100_0700_4000. LI with V=48'h0000_1234_0010 -> cmd_err_o pulse, no word.
- Opcode 8'h50 -> cmd_err_o pulse, no output. With instr_ready_i=0 for 3 cycles, instr_o stays stable and cmd_ready_o=0. Asserting rst_i in EMIT_LO clears instr_valid_o asynchronously.
